// File: rtl/mosi_cmd_sequencer.sv
// Steps a pointer through the MOSI command list in RAM port B and hands each fetched
// half-word to the SPI engine, one word per cmd_req.
module mosi_cmd_sequencer #(
  parameter int ADDR_WIDTH  = 13,
  parameter int RAM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  restart,
  input  logic [ADDR_WIDTH-1:0] start_index,
  input  logic [ADDR_WIDTH-1:0] end_index,
  input  logic                  loop_en,
  input  logic                  cmd_req,
  output logic [ADDR_WIDTH-1:0] RAM_addr_B,
  input  logic [15:0]           RAM_data_out_B,
  output logic [15:0]           cmd_word,
  output logic [ADDR_WIDTH-1:0] cmd_index,
  output logic                  cmd_valid,
  output logic                  busy,
  output logic                  wrap_pulse,
  output logic                  list_done,
  output logic                  req_overrun
);

  typedef enum logic [1:0] {IDLE, WAIT, CAPTURE} state_t;

  localparam logic [2:0] LAT = 3'(RAM_LATENCY);

  state_t                state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH-1:0] start_lat;
  logic [2:0]            lat_cnt;
  logic                  run_q;
  logic                  last_q;
  logic                  load;

  assign load = (run & ~run_q) | restart;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= '0;
      start_lat   <= '0;
      lat_cnt     <= '0;
      run_q       <= 1'b0;
      last_q      <= 1'b0;
      RAM_addr_B  <= '0;
      cmd_word    <= '0;
      cmd_index   <= '0;
      cmd_valid   <= 1'b0;
      busy        <= 1'b0;
      wrap_pulse  <= 1'b0;
      list_done   <= 1'b0;
      req_overrun <= 1'b0;
    end else begin
      run_q      <= run;
      cmd_valid  <= 1'b0;
      wrap_pulse <= 1'b0;
      if (load) begin
        // a load aborts any fetch in flight, including one about to capture
        ptr         <= start_index;
        start_lat   <= start_index;
        list_done   <= 1'b0;
        req_overrun <= 1'b0;
        busy        <= 1'b0;
        state       <= IDLE;
      end else begin
        if (cmd_req && busy) req_overrun <= 1'b1;
        case (state)
          IDLE: begin
            if (cmd_req && run) begin
              RAM_addr_B <= ptr;
              lat_cnt    <= LAT;
              busy       <= 1'b1;
              last_q     <= 1'b0;
              state      <= WAIT;
              if (ptr == end_index) begin
                if (loop_en) begin
                  ptr        <= start_lat;
                  wrap_pulse <= 1'b1;
                end else begin
                  last_q <= 1'b1;
                end
              end else begin
                ptr <= ptr + 1'b1;
              end
            end
          end
          WAIT: begin
            // data is valid RAM_LATENCY edges after the address change
            lat_cnt <= lat_cnt - 1'b1;
            if (lat_cnt == 3'd1) state <= CAPTURE;
          end
          CAPTURE: begin
            cmd_word  <= RAM_data_out_B;
            cmd_index <= RAM_addr_B;
            cmd_valid <= 1'b1;
            busy      <= 1'b0;
            if (last_q) list_done <= 1'b1;
            state     <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mosi_cmd_sequencer.sv
// Drives two sequencers (RAM latency 1 and 3) with shared stimulus; a list-level model
// queues expected words at accept time and a negedge monitor compares them.
module tb_mosi_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst, run, restart, loop, req;
  logic [12:0] sidx, eidx;
  logic [15:0] mem [8192];

  logic [12:0] a0, a1, i0, i1;
  logic [15:0] rd0, rd1, w0, w1, p1a, p1b;
  logic        v0, v1, b0, b1, wp0, wp1, ld0, ld1, ov0, ov1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  mosi_cmd_sequencer #(.ADDR_WIDTH(13), .RAM_LATENCY(1)) u_l1 (
    .clk(clk), .reset(rst), .run(run), .restart(restart), .start_index(sidx),
    .end_index(eidx), .loop_en(loop), .cmd_req(req), .RAM_addr_B(a0),
    .RAM_data_out_B(rd0), .cmd_word(w0), .cmd_index(i0), .cmd_valid(v0),
    .busy(b0), .wrap_pulse(wp0), .list_done(ld0), .req_overrun(ov0));

  mosi_cmd_sequencer #(.ADDR_WIDTH(13), .RAM_LATENCY(3)) u_l3 (
    .clk(clk), .reset(rst), .run(run), .restart(restart), .start_index(sidx),
    .end_index(eidx), .loop_en(loop), .cmd_req(req), .RAM_addr_B(a1),
    .RAM_data_out_B(rd1), .cmd_word(w1), .cmd_index(i1), .cmd_valid(v1),
    .busy(b1), .wrap_pulse(wp1), .list_done(ld1), .req_overrun(ov1));

  // behavioural RAMs: read data appears LAT edges after the address
  always @(posedge clk) begin
    rd0 <= mem[a0];
    p1a <= mem[a1];
    p1b <= p1a;
    rd1 <= p1b;
  end

  typedef struct {
    logic [15:0] w;
    int          idx;
    bit          last;
    int          due;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   lat [2] = '{1, 3};
  int   mptr [2], mst [2], busy_until [2], wrap_at [2];
  bit   mdone [2], movr [2];
  bit   run_prev;

  task automatic chk(string nm, int d, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s dut%0d cyc=%0d act=%0h exp=%0h", nm, d, cyc, act, exp);
    end
  endtask

  task automatic model_step(int d, bit ld);
    exp_t e;
    if (rst) begin
      mptr[d] = 0; mst[d] = 0; mdone[d] = 0; movr[d] = 0;
      busy_until[d] = 0; wrap_at[d] = -1;
      if (d == 0) q0.delete(); else q1.delete();
    end else if (ld) begin
      if (cyc <= busy_until[d]) begin
        if (d == 0) void'(q0.pop_back()); else void'(q1.pop_back());
      end
      mptr[d] = int'(sidx); mst[d] = int'(sidx);
      mdone[d] = 0; movr[d] = 0; busy_until[d] = 0;
    end else if (req) begin
      if (cyc <= busy_until[d]) movr[d] = 1;
      else if (run) begin
        e.w = mem[mptr[d]]; e.idx = mptr[d];
        e.last = (mptr[d] == int'(eidx)) && !loop;
        e.due = cyc + lat[d] + 1;
        if (d == 0) q0.push_back(e); else q1.push_back(e);
        busy_until[d] = e.due;
        if (mptr[d] == int'(eidx)) begin
          if (loop) begin mptr[d] = mst[d]; wrap_at[d] = cyc; end
        end else mptr[d] = (mptr[d] + 1) % 8192;
      end
    end
  endtask

  always @(posedge clk) begin
    bit ld;
    cyc = cyc + 1;
    ld = (run && !run_prev) || restart;
    model_step(0, ld);
    model_step(1, ld);
    run_prev = rst ? 1'b0 : run;
  end

  task automatic mon(int d, bit v, logic [15:0] w, logic [12:0] idx, bit b, bit wp, bit ldn, bit ov);
    exp_t e;
    int   n;
    n = (d == 0) ? q0.size() : q1.size();
    if (v) begin
      if (n == 0) chk("unexpected_valid", d, 1, 0);
      else begin
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        chk("cmd_word", d, int'(w), int'(e.w));
        chk("cmd_index", d, int'(idx), e.idx);
        chk("valid_cycle", d, cyc, e.due);
        if (e.last) mdone[d] = 1;
      end
    end else if (n > 0) begin
      e = (d == 0) ? q0[0] : q1[0];
      if (e.due <= cyc) chk("missing_valid", d, 0, 1);
    end
    chk("busy", d, int'(b), int'(cyc < busy_until[d]));
    chk("wrap_pulse", d, int'(wp), int'(wrap_at[d] == cyc));
    chk("list_done", d, int'(ldn), int'(mdone[d]));
    chk("req_overrun", d, int'(ov), int'(movr[d]));
  endtask

  always @(negedge clk) begin
    if (cyc > 0) begin
      mon(0, v0, w0, i0, b0, wp0, ld0, ov0);
      mon(1, v1, w1, i1, b1, wp1, ld1, ov1);
    end
  end

  task automatic check_zero();
    chk("rst_addr", 0, int'(a0), 0);   chk("rst_addr", 1, int'(a1), 0);
    chk("rst_word", 0, int'(w0), 0);   chk("rst_word", 1, int'(w1), 0);
    chk("rst_index", 0, int'(i0), 0);  chk("rst_index", 1, int'(i1), 0);
    chk("rst_flags", 0, int'({v0, b0, wp0, ld0, ov0}), 0);
    chk("rst_flags", 1, int'({v1, b1, wp1, ld1, ov1}), 0);
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reqs(int n, int gap);
    repeat (n) begin
      req = 1; tick(1); req = 0; tick(gap);
    end
  endtask

  task automatic reload(int s, int e, bit lp);
    sidx = 13'(s); eidx = 13'(e); loop = lp;
    restart = 1; tick(1); restart = 0; tick(1);
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 16'($urandom);
    for (int i = 0; i < 4; i++) mem[10 + i] = 16'hA000 + 16'(i);
    rst = 1; run = 0; restart = 0; loop = 0; req = 0; sidx = 0; eidx = 0;
    tick(3);
    check_zero();
    rst = 0; tick(2);

    sidx = 10; eidx = 13; loop = 0; run = 1; tick(3);
    reqs(5, 3);                      // 4-cycle spacing: latency-3 unit overruns
    reload(10, 13, 0);
    reqs(5, 5);
    reload(100, 101, 1);
    reqs(5, 5);
    reload(8190, 1, 0);
    reqs(4, 5);

    req = 1; tick(2); req = 0; tick(6);   // overrun
    reqs(1, 6);
    reload(20, 30, 0);

    req = 1; tick(1); req = 0;            // restart mid-fetch
    restart = 1; tick(1); restart = 0; tick(1);
    reqs(2, 6);

    req = 1; tick(1); req = 0;            // reset mid-fetch
    rst = 1; tick(1);
    check_zero();
    rst = 0; tick(3);
    reqs(2, 6);

    req = 1; tick(1); req = 0; run = 0;   // run falls mid-fetch
    tick(6);
    reqs(1, 6);
    run = 1; tick(2);
    reqs(2, 6);

    for (int c = 0; c < 4000; c++) begin
      req = ($urandom_range(0, 3) == 0);
      restart = ($urandom_range(0, 59) == 0);
      if (restart) begin
        sidx = ($urandom_range(0, 1) == 0) ? 13'($urandom_range(8185, 8191)) : 13'($urandom);
        loop = $urandom_range(0, 1);
      end
      if ($urandom_range(0, 79) == 0) eidx = sidx + 13'($urandom_range(0, 8));
      if ($urandom_range(0, 149) == 0) run = ~run;
      rst = ($urandom_range(0, 799) == 0);
      tick(1);
    end
    req = 0; restart = 0; rst = 0;
    tick(10);
    chk("queue_empty", 0, q0.size(), 0);
    chk("queue_empty", 1, q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
